// File: rtl/xadc_drp_reader.sv
// DRP read master for an XADC in channel-sequencer mode: reads masked VAUX results
// on end-of-conversion, optionally averages per channel, and streams {chan, sample}.
module xadc_drp_reader #(
  parameter logic [15:0] CH_MASK  = 16'h0020,
  parameter int unsigned OUT_BITS = 12,
  parameter int unsigned AVG_LOG2 = 0,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                eoc_i,
  input  logic [4:0]          channel_i,
  output logic                den_o,
  output logic [6:0]          daddr_o,
  output logic                dwe_o,
  input  logic                drdy_i,
  input  logic [15:0]         do_i,
  output logic [OUT_BITS-1:0] data_o,
  output logic [3:0]          chan_o,
  output logic                valid_o,
  input  logic                ready_i,
  input  logic                clr_i,
  output logic                overrun_o,
  output logic                miss_o,
  output logic                timeout_o
);

  localparam int unsigned AW = 12 + AVG_LOG2;
  localparam int unsigned CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned SH = AVG_LOG2 + 12 - OUT_BITS;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, ACC} state_t;

  state_t          state;
  logic [3:0]      ch;
  logic [TW-1:0]   tmr;
  logic [11:0]     sample;
  logic [AW-1:0]   acc_q [16];
  logic [CW-1:0]   cnt_q [16];

  logic                accept;
  logic                last;
  logic [AW-1:0]       sum;
  logic [OUT_BITS-1:0] result;
  logic                unused_do;

  assign dwe_o     = 1'b0;
  assign unused_do = ^do_i[3:0];

  // The accumulator cannot exceed 2^AW-1, so one shift by AVG_LOG2+(12-OUT_BITS)
  // equals averaging then keeping the top OUT_BITS of the 12-bit mean.
  always_comb begin
    accept = eoc_i && channel_i[4] && CH_MASK[channel_i[3:0]];
    sum    = acc_q[ch] + AW'(sample);
    last   = (cnt_q[ch] == CW'((1 << AVG_LOG2) - 1));
    result = OUT_BITS'(sum >> SH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ch        <= '0;
      tmr       <= '0;
      sample    <= '0;
      den_o     <= 1'b0;
      daddr_o   <= '0;
      data_o    <= '0;
      chan_o    <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      miss_o    <= 1'b0;
      timeout_o <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      den_o <= 1'b0;
      if (clr_i) begin
        overrun_o <= 1'b0;
        miss_o    <= 1'b0;
        timeout_o <= 1'b0;
      end
      if (valid_o && ready_i) valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            ch      <= channel_i[3:0];
            den_o   <= 1'b1;
            daddr_o <= 7'h10 + {3'b000, channel_i[3:0]};
            state   <= REQ;
          end
        end
        REQ: begin
          tmr   <= TW'(TIMEOUT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (drdy_i) begin
            sample <= do_i[15:4];
            state  <= ACC;
          end else if (tmr == '0) begin
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        ACC: begin
          if (last) begin
            acc_q[ch] <= '0;
            cnt_q[ch] <= '0;
            if (!valid_o || ready_i) begin
              data_o  <= result;
              chan_o  <= ch;
              valid_o <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end else begin
            acc_q[ch] <= sum;
            cnt_q[ch] <= cnt_q[ch] + CW'(1);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Placed after the clear so a coinciding set wins.
      if (accept && state != IDLE) miss_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Directed bench for xadc_drp_reader: a default/short-timeout instance (A) and an
// averaging instance (B); monitors pop expected words and DRP addresses from queues.
module tb_xadc_drp_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b0;
  logic        eoc   = 1'b0;
  logic        sel   = 1'b0;
  logic        drdy  = 1'b0;
  logic        ready = 1'b1;
  logic        clr   = 1'b0;
  logic [4:0]  channel = '0;
  logic [15:0] dval    = '0;

  logic        den_a, dwe_a, valid_a, ovr_a, miss_a, tmo_a;
  logic [6:0]  daddr_a;
  logic [11:0] data_a;
  logic [3:0]  chan_a;

  logic        den_b, dwe_b, valid_b, ovr_b, miss_b, tmo_b;
  logic [6:0]  daddr_b;
  logic [9:0]  data_b;
  logic [3:0]  chan_b;

  xadc_drp_reader #(.CH_MASK(16'h0020), .OUT_BITS(12), .AVG_LOG2(0), .TIMEOUT(8)) u_a (
    .clk(clk), .rst(rst), .eoc_i(eoc & ~sel), .channel_i(channel),
    .den_o(den_a), .daddr_o(daddr_a), .dwe_o(dwe_a),
    .drdy_i(drdy & ~sel), .do_i(dval),
    .data_o(data_a), .chan_o(chan_a), .valid_o(valid_a), .ready_i(ready),
    .clr_i(clr), .overrun_o(ovr_a), .miss_o(miss_a), .timeout_o(tmo_a)
  );

  xadc_drp_reader #(.CH_MASK(16'h0020), .OUT_BITS(10), .AVG_LOG2(2), .TIMEOUT(64)) u_b (
    .clk(clk), .rst(rst), .eoc_i(eoc & sel), .channel_i(channel),
    .den_o(den_b), .daddr_o(daddr_b), .dwe_o(dwe_b),
    .drdy_i(drdy & sel), .do_i(dval),
    .data_o(data_b), .chan_o(chan_b), .valid_o(valid_b), .ready_i(ready),
    .clr_i(clr), .overrun_o(ovr_b), .miss_o(miss_b), .timeout_o(tmo_b)
  );

  int checks   = 0;
  int failures = 0;

  logic [15:0] qa[$];
  logic [13:0] qb[$];
  logic [6:0]  qaddr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (valid_a && ready) begin
        if (qa.size() == 0) chk("a_unexpected_word", {chan_a, data_a}, 32'hFFFF_FFFF);
        else chk("a_word", {chan_a, data_a}, qa.pop_front());
      end
      if (valid_b && ready) begin
        if (qb.size() == 0) chk("b_unexpected_word", {chan_b, data_b}, 32'hFFFF_FFFF);
        else chk("b_word", {chan_b, data_b}, qb.pop_front());
      end
      if (den_a) begin
        if (qaddr.size() == 0) chk("a_unexpected_den", daddr_a, 32'hFFFF_FFFF);
        else chk("a_daddr", daddr_a, qaddr.pop_front());
      end
    end
  end

  task automatic read(input logic s, input logic [4:0] ch, input logic [15:0] d, input int dly);
    sel = s; eoc = 1'b1; channel = ch;
    tick();
    eoc = 1'b0;
    chk("den_latency", s ? den_b : den_a, 1);
    repeat (dly) tick();
    drdy = 1'b1; dval = d;
    tick();
    drdy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("rst_den", den_a, 0);
    chk("rst_daddr", daddr_a, 0);
    chk("rst_dwe", dwe_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_chan", chan_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_flags", {ovr_a, miss_a, tmo_a}, 0);
    rst = 1'b1;
    tick();

    // Single read: drdy two cycles after den, valid two cycles after drdy
    qaddr.push_back(7'h15);
    qa.push_back({4'd5, 12'hABC});
    read(1'b0, 5'h15, 16'hABC0, 2);
    chk("single_valid_d1", valid_a, 0);
    tick();
    chk("single_valid_d2", valid_a, 1);
    chk("single_data", data_a, 12'hABC);
    chk("single_chan", chan_a, 5);
    tick();

    // Mask filtering: 14 (masked out), 03 (not aux), 05 (aux bit clear), then 15
    eoc = 1'b1; channel = 5'h14; tick();
    channel = 5'h03; tick();
    channel = 5'h05; tick();
    eoc = 1'b0; tick();
    chk("mask_no_den", den_a, 0);
    qaddr.push_back(7'h15);
    qa.push_back({4'd5, 12'h123});
    read(1'b0, 5'h15, 16'h1230, 1);
    tick(); tick();

    // Averaging on the AVG_LOG2=2, OUT_BITS=10 instance
    read(1'b1, 5'h15, 16'h1000, 1); tick();
    read(1'b1, 5'h15, 16'h2000, 1); tick();
    read(1'b1, 5'h15, 16'h3000, 1); tick();
    chk("avg_no_early_out", valid_b, 0);
    qb.push_back({4'd5, 10'h0A0});
    read(1'b1, 5'h15, 16'h4010, 1);
    tick();
    chk("avg_valid", valid_b, 1);
    chk("avg_data", data_b, 10'h0A0);
    sel = 1'b0;
    tick();

    // Backpressure: second emit while the first word is still held
    ready = 1'b0;
    qaddr.push_back(7'h15);
    qa.push_back({4'd5, 12'h111});
    read(1'b0, 5'h15, 16'h1110, 1);
    tick();
    chk("bp_first_valid", valid_a, 1);
    chk("bp_no_overrun_yet", ovr_a, 0);
    qaddr.push_back(7'h15);
    read(1'b0, 5'h15, 16'h2220, 1);
    tick();
    chk("bp_overrun", ovr_a, 1);
    chk("bp_held_data", data_a, 12'h111);
    chk("bp_held_valid", valid_a, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("bp_clr_overrun", ovr_a, 0);
    chk("bp_still_valid", valid_a, 1);
    ready = 1'b1;
    tick(); tick();
    chk("bp_drained", valid_a, 0);

    // Timeout (TIMEOUT=8) with a second accepted EOC during WAIT, clr coinciding
    qaddr.push_back(7'h15);
    eoc = 1'b1; channel = 5'h15;
    tick();                       // t+1
    eoc = 1'b0;
    chk("to_den", den_a, 1);
    tick();                       // t+2, WAIT
    eoc = 1'b1; clr = 1'b1;
    tick();                       // t+3
    eoc = 1'b0; clr = 1'b0;
    chk("miss_set_wins", miss_a, 1);
    chk("to_not_yet_t3", tmo_a, 0);
    repeat (6) tick();            // t+9
    chk("to_not_yet_t9", tmo_a, 0);
    tick();                       // t+10
    chk("to_set_t10", tmo_a, 1);
    chk("to_no_word", valid_a, 0);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("to_clr_flags", {miss_a, tmo_a}, 0);

    // Reset mid-WAIT, then a stray drdy while idle
    qaddr.push_back(7'h15);
    eoc = 1'b1; channel = 5'h15;
    tick();
    eoc = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_den", den_a, 0);
    chk("rst_mid_daddr", daddr_a, 0);
    chk("rst_mid_data", data_a, 0);
    chk("rst_mid_chan", chan_a, 0);
    chk("rst_mid_valid", valid_a, 0);
    chk("rst_mid_flags", {ovr_a, miss_a, tmo_a}, 0);
    tick();
    rst = 1'b1;
    tick();
    drdy = 1'b1; dval = 16'hFFF0;
    tick();
    drdy = 1'b0;
    repeat (3) tick();
    chk("rst_stray_drdy", valid_a, 0);
    chk("rst_stray_flags", {ovr_a, miss_a, tmo_a}, 0);

    // Recovery read after reset
    qaddr.push_back(7'h15);
    qa.push_back({4'd5, 12'h456});
    read(1'b0, 5'h15, 16'h4560, 1);
    tick(); tick();

    repeat (3) tick();
    chk("end_qa_empty", qa.size(), 0);
    chk("end_qb_empty", qb.size(), 0);
    chk("end_qaddr_empty", qaddr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
